// File: rtl/logic_unit_if.sv
// Handshake/operand bundle between operand issue, logic_unit_pipe and writeback.
// Reduction flag signals exist only when LOGIC_UNIT_REDUCE_EN is defined.
interface logic_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             use_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             zero;
    logic [WIDTH-1:0] acc;
`ifdef LOGIC_UNIT_REDUCE_EN
    logic             red_and;
    logic             red_or;
    logic             red_xor;
`endif

    modport master (
        output in_valid, a, b, op, use_acc, acc_clr, out_ready,
        input  in_ready, out_valid, s, zero, acc
`ifdef LOGIC_UNIT_REDUCE_EN
        , input red_and, red_or, red_xor
`endif
    );

    modport slave (
        input  in_valid, a, b, op, use_acc, acc_clr, out_ready,
        output in_ready, out_valid, s, zero, acc
`ifdef LOGIC_UNIT_REDUCE_EN
        , output red_and, red_or, red_xor
`endif
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered eight-op bitwise logic unit with valid/ready handshake and chaining accumulator.
// Optional registered reduction flags of the result: define LOGIC_UNIT_REDUCE_EN.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = 3
) (
    input  logic           clk,
    input  logic           rst,
    logic_unit_if.slave    bus
);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_NAND = OP_W'(3);
    localparam logic [OP_W-1:0] OP_NOR  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XNOR = OP_W'(5);
    localparam logic [OP_W-1:0] OP_NOT  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_PASS = OP_W'(7);

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             zero_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] result_c;
    logic             accept_c;

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept_c     = bus.in_valid && bus.in_ready;

    // A same-cycle clear is seen by the op before the result reloads acc.
    always_comb begin
        x_c = bus.a;
        if (bus.use_acc) begin
            x_c = bus.acc_clr ? '0 : acc_q;
        end
    end

    always_comb begin
        result_c = '0;
        case (bus.op)
            OP_AND:  result_c = x_c & bus.b;
            OP_OR:   result_c = x_c | bus.b;
            OP_XOR:  result_c = x_c ^ bus.b;
            OP_NAND: result_c = ~(x_c & bus.b);
            OP_NOR:  result_c = ~(x_c | bus.b);
            OP_XNOR: result_c = ~(x_c ^ bus.b);
            OP_NOT:  result_c = ~x_c;
            OP_PASS: result_c = bus.b;
            default: result_c = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            zero_q      <= 1'b1;
            acc_q       <= '0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            s_q         <= result_c;
            zero_q      <= (result_c == '0);
            acc_q       <= result_c;
        end else begin
            if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bus.acc_clr) begin
                acc_q <= '0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.zero      = zero_q;
    assign bus.acc       = acc_q;

`ifdef LOGIC_UNIT_REDUCE_EN
    logic red_and_q;
    logic red_or_q;
    logic red_xor_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            red_and_q <= 1'b1;
            red_or_q  <= 1'b0;
            red_xor_q <= 1'b0;
        end else if (accept_c) begin
            red_and_q <= &result_c;
            red_or_q  <= |result_c;
            red_xor_q <= ^result_c;
        end
    end

    assign bus.red_and = red_and_q;
    assign bus.red_or  = red_or_q;
    assign bus.red_xor = red_xor_q;
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: vector table plus scoreboard of expected results.
module tb_logic_unit_pipe;
    logic clk;
    logic rst;

    logic_unit_if #(.WIDTH(32), .OP_W(3)) bus ();

    logic_unit_pipe #(.WIDTH(32), .OP_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_s;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] sb[$];
    int          total;
    int          passed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    // Drive one cycle from a negedge; pops the result leaving this cycle, pushes one accepted now.
    task automatic step(input logic iv, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ua, input logic clr,
                        input logic ordy, input logic [31:0] exp_s, output bit accepted);
        logic [31:0] e;
        bus.in_valid  = iv;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.use_acc   = ua;
        bus.acc_clr   = clr;
        bus.out_ready = ordy;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL sb_underflow: got unexpected result %h expected none", bus.s);
            end else begin
                e = sb.pop_front();
                check("sb_s", bus.s, e);
                check("sb_zero", 32'(bus.zero), 32'(e == 32'h0));
            end
        end
        accepted = iv && bus.in_ready;
        if (accepted) sb.push_back(exp_s);
        @(negedge clk);
    endtask

    initial begin
        bit ac;
        total  = 0;
        passed = 0;
        vecs[0] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[1] = '{3'b000, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000};
        vecs[2] = '{3'b001, 32'hFFFF0000, 32'h0000FFFF, 32'hFFFFFFFF};
        vecs[3] = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vecs[4] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[5] = '{3'b100, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[6] = '{3'b101, 32'h12345678, 32'h12345678, 32'hFFFFFFFF};
        vecs[7] = '{3'b110, 32'h0000FFFF, 32'h00001234, 32'hFFFF0000};
        vecs[8] = '{3'b111, 32'h11111111, 32'hCAFEBABE, 32'hCAFEBABE};
        vecs[9] = '{3'b100, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000};

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
        bus.use_acc = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_s", bus.s, 32'h0);
        check("rst_zero", 32'(bus.zero), 32'h1);
        check("rst_acc", bus.acc, 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
`ifdef LOGIC_UNIT_REDUCE_EN
        check("rst_red_and", 32'(bus.red_and), 32'h1);
        check("rst_red_or", 32'(bus.red_or), 32'h0);
        check("rst_red_xor", 32'(bus.red_xor), 32'h0);
`endif
        rst = 1'b0;

        // Back-to-back accepts, one per cycle
        for (int i = 0; i < 10; i++) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0, 1'b1, vecs[i].exp_s, ac);
            check("vec_accept", 32'(ac), 32'h1);
            check("vec_out_valid", 32'(bus.out_valid), 32'h1);
            check("vec_acc", bus.acc, vecs[i].exp_s);
        end

        // Stall with a pending result
        step(1'b1, 3'b000, 32'h00000808, 32'h00000808, 1'b0, 1'b0, 1'b1, 32'h00000808, ac);
        check("stall_setup_accept", 32'(ac), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 3'b001, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 32'h0, ac);
            check("stall_no_accept", 32'(ac), 32'h0);
            check("stall_s", bus.s, 32'h00000808);
            check("stall_acc", bus.acc, 32'h00000808);
            check("stall_out_valid", 32'(bus.out_valid), 32'h1);
        end
        step(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, ac);
        check("stall_clr_acc", bus.acc, 32'h0);
        check("stall_clr_s", bus.s, 32'h00000808);
        step(1'b1, 3'b001, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, ac);
        check("release_accept", 32'(ac), 32'h1);
        check("release_zero", 32'(bus.zero), 32'h1);

        // Accumulator chain, same-cycle clear beats stale acc, result reloads acc
        step(1'b1, 3'b111, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, ac);
        step(1'b1, 3'b001, 32'h0, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h00000001, ac);
        check("chain1_acc", bus.acc, 32'h00000001);
        step(1'b1, 3'b010, 32'hFFFFFFFF, 32'h00000003, 1'b1, 1'b0, 1'b1, 32'h00000002, ac);
        check("chain2_acc", bus.acc, 32'h00000002);
        step(1'b1, 3'b110, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFD, ac);
        check("chain3_acc", bus.acc, 32'hFFFFFFFD);
        step(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, ac);
        check("idle_clr_acc", bus.acc, 32'h0);
        check("drain_out_valid", 32'(bus.out_valid), 32'h0);
        check("drain_s_hold", bus.s, 32'hFFFFFFFD);
        check("drain_zero_hold", 32'(bus.zero), 32'h0);

        // Reset overrides a pending result and a concurrent input
        step(1'b1, 3'b111, 32'h0, 32'h00000055, 1'b0, 1'b0, 1'b0, 32'h00000055, ac);
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.op = 3'b111; bus.b = 32'h00000099; bus.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("rst2_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst2_s", bus.s, 32'h0);
        check("rst2_zero", 32'(bus.zero), 32'h1);
        check("rst2_acc", bus.acc, 32'h0);
        step(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, ac);
        check("rst2_not_captured", 32'(bus.out_valid), 32'h0);

        step(1'b1, 3'b111, 32'hFFFFFFFF, 32'h00000007, 1'b0, 1'b0, 1'b1, 32'h00000007, ac);
`ifdef LOGIC_UNIT_REDUCE_EN
        check("red_and", 32'(bus.red_and), 32'h0);
        check("red_or", 32'(bus.red_or), 32'h1);
        check("red_xor", 32'(bus.red_xor), 32'h1);
`endif
        for (int i = 0; i < 4 && sb.size() > 0; i++)
            step(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, ac);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
